// File: rtl/mem_stage.sv
// Data-memory stage: loads and stores against an internal word RAM; ALU results pass straight through.
// Latency 1 cycle for non-memory ops, LATENCY+1 cycles for memory ops; stall is held while an access is in flight.
// MEM_STAGE_TRACE_EN adds a cycle counter and prints a line for each completed memory access.
module mem_stage #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        valid_in,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  input  logic        mem_read,
  input  logic        mem_write,
  output logic        stall,
  output logic [31:0] wb_data,
  output logic        wb_valid,
  output logic        misaligned
);
  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t        state;
  logic [3:0]    counter;
  logic [31:0]   addr_q;
  logic [31:0]   data_q;
  logic          write_q;
  logic [31:0]   mem [DEPTH_WORDS];
  logic          is_mem;
  logic          done;
  logic          aligned;
  logic [AW-1:0] idx;

  assign is_mem  = mem_read | mem_write;
  assign idx     = addr_q[AW+1:2];
  assign aligned = (addr_q[1:0] == 2'b00);
  assign done    = (state == ACCESS) && (counter == 4'd0);
  assign stall   = ((state == IDLE) && valid_in && is_mem) ||
                   ((state == ACCESS) && (counter != 4'd0));

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state      <= IDLE;
      counter    <= 4'd0;
      addr_q     <= 32'd0;
      data_q     <= 32'd0;
      write_q    <= 1'b0;
      wb_data    <= 32'd0;
      wb_valid   <= 1'b0;
      misaligned <= 1'b0;
    end else begin
      wb_valid   <= 1'b0;
      misaligned <= 1'b0;
      case (state)
        IDLE: begin
          if (valid_in) begin
            if (is_mem) begin
              // A set mem_write wins when both op bits are set.
              addr_q  <= alu_result;
              data_q  <= store_data;
              write_q <= mem_write;
              counter <= 4'(LATENCY - 1);
              state   <= ACCESS;
            end else begin
              wb_data  <= alu_result;
              wb_valid <= 1'b1;
            end
          end
        end
        ACCESS: begin
          if (counter != 4'd0) begin
            counter <= counter - 4'd1;
          end else begin
            wb_valid <= 1'b1;
            state    <= IDLE;
            if (!aligned) begin
              wb_data    <= 32'd0;
              misaligned <= 1'b1;
            end else if (write_q) begin
              wb_data <= addr_q;
            end else begin
              wb_data <= mem[idx];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Reset forces state to IDLE asynchronously, so an aborted store never reaches the array.
  always_ff @(posedge clk) begin
    if (done && aligned && write_q) begin
      mem[idx] <= data_q;
    end
  end

`ifdef MEM_STAGE_TRACE_EN
  integer cycle_cnt;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      cycle_cnt <= 0;
    end else begin
      cycle_cnt <= cycle_cnt + 1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_b && done) begin
      $display("---- mem_stage cycle %0d ----", cycle_cnt);
      $display("  op=%s addr=%h data=%h misaligned=%0d",
               write_q ? "SW" : "LW", addr_q,
               write_q ? data_q : (aligned ? mem[idx] : 32'd0), !aligned);
    end
  end
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Table-driven bench for mem_stage with a scoreboard of expected write-back words and arrival cycles.
module tb_mem_stage;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic        valid_in = 1'b0;
  logic [31:0] alu_result = 32'd0;
  logic [31:0] store_data = 32'd0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic        stall;
  logic [31:0] wb_data;
  logic        wb_valid;
  logic        misaligned;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] data;
    logic        mis;
    int          cyc;
  } exp_t;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] alu;
    logic [31:0] sd;
    logic [31:0] exp;
    logic        mis;
  } vec_t;

  exp_t sb[$];
  exp_t mon_e;
  vec_t vecs[13];

  mem_stage #(.DEPTH_WORDS(256), .LATENCY(LAT)) dut (
    .clk        (clk),
    .rst_b      (rst_b),
    .valid_in   (valid_in),
    .alu_result (alu_result),
    .store_data (store_data),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .stall      (stall),
    .wb_data    (wb_data),
    .wb_valid   (wb_valid),
    .misaligned (misaligned)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (rst_b) begin
      if (wb_valid) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_wb got %h want none", wb_data);
        end else begin
          mon_e = sb.pop_front();
          check("wb_data", wb_data, mon_e.data);
          check("misaligned", {31'd0, misaligned}, {31'd0, mon_e.mis});
          check("wb_cycle", 32'(cyc), 32'(mon_e.cyc));
        end
      end else begin
        check("mis_idle", {31'd0, misaligned}, 32'd0);
      end
    end
  end

  // Present one instruction, hold it while stalled, push its expected completion.
  task automatic issue(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] ew, input logic em);
    int   t0;
    int   nst;
    bit   adv;
    exp_t e;
    valid_in   = 1'b1;
    mem_read   = rd;
    mem_write  = wr;
    alu_result = a;
    store_data = d;
    t0  = -1;
    nst = 0;
    adv = 1'b0;
    for (int i = 0; i < 20 && !adv; i++) begin
      @(negedge clk);
      if (t0 < 0) begin
        t0     = cyc;
        e.data = ew;
        e.mis  = em;
        e.cyc  = t0 + ((rd | wr) ? LAT + 1 : 1);
        sb.push_back(e);
      end
      if (stall) nst++;
      else adv = 1'b1;
      @(posedge clk);
      #1;
    end
    if (!adv) begin
      tests++;
      fails++;
      $display("FAIL stall_timeout got stalled want release at %h", a);
    end
    check("stall_cycles", 32'(nst), (rd | wr) ? 32'(LAT) : 32'd0);
    valid_in  = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    //          rd    wr    alu            sd             exp            mis
    vecs[0]  = '{1'b0, 1'b0, 32'h0000_0007, 32'h0,         32'h0000_0007, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 32'hFFFF_FFFF, 32'h1234_5678, 32'hFFFF_FFFF, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0010, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 32'h0000_0013, 32'h0,         32'h0000_0000, 1'b1};
    vecs[5]  = '{1'b0, 1'b1, 32'h0000_0012, 32'h0000_CAFE, 32'h0000_0000, 1'b1};
    vecs[6]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 32'h0000_0400, 32'h1111_2222, 32'h0000_0400, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,         32'h1111_2222, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 32'h0000_0008, 32'h1234_5678, 32'h0000_0008, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 32'h0000_0008, 32'h0,         32'h1234_5678, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 32'h0000_03FC, 32'hA5A5_5A5A, 32'h0000_03FC, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0,         32'hA5A5_5A5A, 1'b0};

    #1;
    check("rst_wb_data", wb_data, 32'd0);
    check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    check("rst_misaligned", {31'd0, misaligned}, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_b = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 13; i++) begin
      issue(vecs[i].rd, vecs[i].wr, vecs[i].alu, vecs[i].sd, vecs[i].exp, vecs[i].mis);
      if (i % 3 == 2) idle(1);
    end

    // Seed word 0x20 with zero, then abort a store to it with reset.
    issue(1'b0, 1'b1, 32'h0000_0020, 32'h0, 32'h0000_0020, 1'b0);
    idle(3);
    valid_in   = 1'b1;
    mem_write  = 1'b1;
    alu_result = 32'h0000_0020;
    store_data = 32'hABCD_0123;
    @(posedge clk);
    #1;
    check("access_stall", {31'd0, stall}, 32'd1);
    valid_in  = 1'b0;
    mem_write = 1'b0;
    rst_b     = 1'b0;
    #1;
    check("abort_wb_data", wb_data, 32'd0);
    check("abort_wb_valid", {31'd0, wb_valid}, 32'd0);
    check("abort_misaligned", {31'd0, misaligned}, 32'd0);
    check("abort_stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_b = 1'b1;
    @(posedge clk);
    #1;
    issue(1'b1, 1'b0, 32'h0000_0020, 32'h0, 32'h0000_0000, 1'b0);

    // Back-to-back ALU, load, ALU.
    issue(1'b0, 1'b0, 32'h0000_0055, 32'h0, 32'h0000_0055, 1'b0);
    issue(1'b1, 1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0);
    issue(1'b0, 1'b0, 32'h0000_0066, 32'h0, 32'h0000_0066, 1'b0);

    for (int i = 0; i < 20 && sb.size() != 0; i++) idle(1);
    idle(2);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline stage directly downstream of the execute stage.
- Consumes the ALU result as a byte address or pass-through value, and performs data-memory loads/stores against an internal word-addressed memory with fixed multi-cycle access latency.
- Drives a stall back upstream while an access is in flight.
- Presents a registered write-back word plus a valid pulse to the write-back stage.

Parameters:
- DEPTH_WORDS, 256: number of 32-bit words in the data memory; must be a power of 2, at least 2.
- LATENCY, 2: wait cycles per memory access, in the range 1..15.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_b  input  1  asynchronous, active-low reset.
- valid_in  input  1  execute stage presents a valid instruction this cycle.
- alu_result  input  32  ALU output; byte address for memory ops, result for all other ops.
- store_data  input  32  data to store (rt value).
- mem_read  input  1  instruction is a load (lw).
- mem_write  input  1  instruction is a store (sw).
- stall  output  1  combinational; upstream must hold its state while high.
- wb_data  output  32  registered write-back value.
- wb_valid  output  1  registered; one-cycle pulse per completed instruction.
- misaligned  output  1  registered; pulses with wb_valid when a memory op had alu_result[1:0] != 0.

Behaviour:
- Reset (async, rst_b=0):
  - state=IDLE, counter=0, wb_data=0, wb_valid=0, misaligned=0.
  - Memory array is not reset.
  - Reset mid-access aborts the access; no memory write occurs.
- is_mem = mem_read | mem_write. If both are set, the op is treated as a store.
- Word index = alu_result[log2(DEPTH_WORDS)+1:2]. Upper address bits are ignored, so addresses wrap modulo DEPTH_WORDS*4.
- State IDLE:
  - valid_in=0: wb_valid<=0; nothing else changes.
  - valid_in=1, is_mem=0: wb_data<=alu_result, wb_valid<=1 next cycle (latency 1); stall=0.
  - valid_in=1, is_mem=1:
    - stall=1 this cycle.
    - Latch address, store_data and op type.
    - counter<=LATENCY-1; state<=ACCESS; wb_valid<=0.
- State ACCESS:
  - Inputs are ignored; upstream keeps presenting the same instruction.
  - stall = (counter != 0).
  - counter != 0: counter decrements; wb_valid stays 0.
  - counter == 0 (final cycle, stall=0, so upstream advances at this edge). At the edge:
    - Aligned store: mem[idx]<=latched store_data; wb_data<=latched address.
    - Aligned load: wb_data<=mem[idx].
    - Misaligned op (address[1:0] != 0): no memory access; wb_data<=0; misaligned<=1.
    - wb_valid<=1; state<=IDLE.
- Timing: an op accepted in cycle T has wb_valid high in cycle T+LATENCY+1, and stall is high for LATENCY cycles (T..T+LATENCY-1).
- A new instruction can be accepted in the cycle wb_valid is high (back-to-back).
- misaligned and wb_valid are cleared the cycle after their pulse unless a new completion occurs.
- Memory read is a synchronous array read; there is no read-during-write hazard, since only one access is outstanding.

Optional Feature:
- Macro MEM_STAGE_TRACE_EN.
- When defined: at each completing edge, $display a banner with a cycle count, followed by op type, address, data, and misaligned flag. The cycle count is an integer counter reset by rst_b and incremented every clock.
- When undefined: no counter and no $display; functionally identical outputs.

Test Plan:
- Reset, then valid_in=1, alu_result=0x0000_0007, no mem op → wb_data=0x7, wb_valid=1 in the next cycle, stall never asserted.
- LATENCY=2: store 0xDEAD_BEEF to 0x10, then load 0x10 → stall high 2 cycles per op; load wb_data=0xDEAD_BEEF at T+3 after its accept.
- Load from 0x13 → misaligned=1, wb_data=0, memory unchanged (a follow-up load of 0x10 still returns 0xDEAD_BEEF).
- DEPTH_WORDS=256: store 0x1111_2222 to 0x400, load from 0x0 → 0x1111_2222 (wrap).
- Assert rst_b=0 during the first ACCESS cycle of a store to 0x20 (previously 0) → outputs zero immediately; a later load of 0x20 returns 0.
- ALU op, load, ALU op issued back-to-back → wb_valid pulses at cycles 1, 4, 5 (LATENCY=2) with the correct data order.
